// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants and the scan-out fetch state encoding.
package vga_pkg;

  localparam int H_ACTIVE        = 640;
  localparam int V_ACTIVE        = 480;
  localparam int AWIDTH_DEF      = 19;
  localparam int DWIDTH_DEF      = 8;
  localparam int FB_BASE_DEF     = 0;
  localparam int FRAME_BYTES_DEF = H_ACTIVE * V_ACTIVE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head; a full FIFO never
// credits a same-cycle pop as free space.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [LW-1:0]    count_r, count_pop_s, count_next_s;
  logic [WIDTH-1:0] dout_r, head_s;
  logic             valid_r, do_push_s, do_pop_s;

  // Effective push/pop and the head value that will be visible next cycle.
  always_comb begin
    full         = (count_r == LW'(DEPTH));
    empty        = (count_r == {LW{1'b0}});
    do_push_s    = push && !full;
    do_pop_s     = pop && !empty;
    rd_next_s    = do_pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    count_pop_s  = do_pop_s ? (count_r - LW'(1)) : count_r;
    count_next_s = do_push_s ? (count_pop_s + LW'(1)) : count_pop_s;
    if (count_pop_s == {LW{1'b0}}) begin
      head_s = din;
    end else begin
      head_s = mem_r[rd_next_s];
    end
  end

  // Storage array; stale contents are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
      dout_r   <= {WIDTH{1'b0}};
      valid_r  <= 1'b0;
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      valid_r  <= (count_next_s != {LW{1'b0}});
      // Empty FIFO keeps showing the last byte it presented.
      if (count_next_s != {LW{1'b0}}) begin
        dout_r <= head_s;
      end
    end
  end

  assign dout  = dout_r;
  assign valid = valid_r;
  assign level = count_r;

endmodule

// File: rtl/vmmu_fetch.sv
// Framebuffer scan-out reader: holds a sequential read address on one arbiter
// source and queues returned bytes for the pixel pipeline.
module vmmu_fetch
  import vga_pkg::*;
#(
  parameter int AWIDTH      = AWIDTH_DEF,
  parameter int DWIDTH      = DWIDTH_DEF,
  parameter int FB_BASE     = FB_BASE_DEF,
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int FIFO_DEPTH  = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1,
  localparam int CW = $clog2(FRAME_BYTES + 1)
) (
  input  logic              MemClk,
  input  logic              nReset,
  input  logic              FrameStart,
  output logic [AWIDTH-1:0] ReqAddr,
  input  logic [DWIDTH-1:0] ReadData,
  input  logic              ReadDataRdy,
  input  logic              PixelPop,
  output logic [DWIDTH-1:0] PixelData,
  output logic              PixelValid,
  output logic [LW-1:0]     Level,
  output logic              Underrun,
  output logic              FrameDone
);

  fetch_state_e      state_r, state_next_s;
  logic [AWIDTH-1:0] addr_r;
  logic [CW-1:0]     cnt_r;
  logic              underrun_r, done_r;
  logic              accept_s, last_s, fifo_pop_s, fifo_full_s, fifo_empty_s;

  // A byte is accepted only while fetching, with real free space, and never
  // on a FrameStart cycle.
  always_comb begin
    accept_s     = (state_r == ST_FETCH) && ReadDataRdy && !fifo_full_s && !FrameStart;
    last_s       = accept_s && (cnt_r == CW'(FRAME_BYTES - 1));
    fifo_pop_s   = PixelPop && !FrameStart;
    state_next_s = state_r;
    if (FrameStart) begin
      state_next_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_IDLE:  state_next_s = ST_IDLE;
        ST_FETCH: state_next_s = last_s ? ST_DONE : ST_FETCH;
        ST_DONE:  state_next_s = ST_DONE;
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge MemClk) begin
    if (!nReset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Address and byte counter move only on accept or restart, so the arbiter
  // can sample ReqAddr at any cycle.
  always_ff @(posedge MemClk) begin
    if (!nReset) begin
      addr_r     <= AWIDTH'(FB_BASE);
      cnt_r      <= {CW{1'b0}};
      underrun_r <= 1'b0;
      done_r     <= 1'b0;
    end else if (FrameStart) begin
      addr_r     <= AWIDTH'(FB_BASE);
      cnt_r      <= {CW{1'b0}};
      underrun_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r <= addr_r + AWIDTH'(1);
        cnt_r  <= cnt_r + CW'(1);
      end
      if (PixelPop && fifo_empty_s) begin
        underrun_r <= 1'b1;
      end
      done_r <= (state_next_s == ST_DONE);
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DWIDTH)
  ) u_fifo (
    .clk   (MemClk),
    .rst_n (nReset),
    .flush (FrameStart),
    .push  (accept_s),
    .din   (ReadData),
    .pop   (fifo_pop_s),
    .dout  (PixelData),
    .valid (PixelValid),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (Level)
  );

  assign ReqAddr   = addr_r;
  assign Underrun  = underrun_r;
  assign FrameDone = done_r;

endmodule

// File: tb/tb_vmmu_fetch.sv
// Scoreboard bench for vmmu_fetch: accepted bytes are queued as they are
// driven and compared when the pixel side pops them.
module tb_vmmu_fetch;

  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int BASE  = 0;
  localparam int FB    = 24;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic          MemClk = 1'b0;
  logic          nReset, FrameStart, ReadDataRdy, PixelPop;
  logic [AW-1:0] ReqAddr;
  logic [DW-1:0] ReadData, PixelData;
  logic          PixelValid, Underrun, FrameDone;
  logic [LW-1:0] Level;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb_q[$];
  int         m_state, m_addr, m_cnt;
  bit         m_under, m_done;
  logic [7:0] m_head;

  always #5 MemClk = ~MemClk;

  vmmu_fetch #(
    .AWIDTH      (AW),
    .DWIDTH      (DW),
    .FB_BASE     (BASE),
    .FRAME_BYTES (FB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .MemClk      (MemClk),
    .nReset      (nReset),
    .FrameStart  (FrameStart),
    .ReqAddr     (ReqAddr),
    .ReadData    (ReadData),
    .ReadDataRdy (ReadDataRdy),
    .PixelPop    (PixelPop),
    .PixelData   (PixelData),
    .PixelValid  (PixelValid),
    .Level       (Level),
    .Underrun    (Underrun),
    .FrameDone   (FrameDone)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One MemClk cycle: drive, advance the reference model at the edge, compare.
  task automatic cycle(input bit rst, input bit fs, input bit rdy,
                       input logic [7:0] d, input bit pop);
    bit full;
    bit accept;
    nReset      = !rst;
    FrameStart  = fs;
    ReadDataRdy = rdy;
    ReadData    = d;
    PixelPop    = pop;
    if (pop && !rst && !fs && sb_q.size() > 0)
      check("pop_data", {24'd0, PixelData}, {24'd0, sb_q[0]});
    @(posedge MemClk);
    if (rst) begin
      m_state = 0; m_addr = BASE; m_cnt = 0; sb_q.delete();
      m_under = 1'b0; m_done = 1'b0; m_head = 8'h00;
    end else if (fs) begin
      m_state = 1; m_addr = BASE; m_cnt = 0; sb_q.delete();
      m_under = 1'b0; m_done = 1'b0;
    end else begin
      full   = (sb_q.size() == DEPTH);
      accept = (m_state == 1) && rdy && !full;
      if (pop) begin
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        else m_under = 1'b1;
      end
      if (accept) begin
        sb_q.push_back(d);
        m_addr++;
        m_cnt++;
        if (m_cnt == FB) begin
          m_state = 2;
          m_done  = 1'b1;
        end
      end
    end
    if (sb_q.size() > 0) m_head = sb_q[0];
    #1;
    check("ReqAddr",    32'(ReqAddr),    32'(m_addr));
    check("Level",      32'(Level),      32'(sb_q.size()));
    check("PixelValid", 32'(PixelValid), 32'(sb_q.size() > 0));
    check("PixelData",  32'(PixelData),  32'(m_head));
    check("Underrun",   32'(Underrun),   32'(m_under));
    check("FrameDone",  32'(FrameDone),  32'(m_done));
  endtask

  initial begin
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("rst_addr", 32'(ReqAddr), 32'(BASE));
    check("rst_level", 32'(Level), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
    check("idle_ignore", 32'(Level), 32'd0);

    // In-order capture and pop
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
    check("t1_level", 32'(Level), 32'd3);
    check("t1_addr", 32'(ReqAddr), 32'd3);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Fill to full, drop the overflow byte, then retry after a pop
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b0, 1'b1, 8'(i + 8'h40), 1'b0);
    check("t2_level", 32'(Level), 32'd16);
    check("t2_addr", 32'(ReqAddr), 32'd16);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
    check("t2_addr17", 32'(ReqAddr), 32'd17);

    // Run to frame end with concurrent pops; surplus pulses ignored
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1, 8'(i + 8'hC0), 1'b1);
    check("t3_done", 32'(FrameDone), 32'd1);
    check("t3_addr", 32'(ReqAddr), 32'(BASE + FB));
    repeat (18) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // FrameStart beats a coincident byte and pop
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'(i + 8'h70), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 8'hAA, 1'b1);
    check("t4_level", 32'(Level), 32'd0);
    check("t4_addr", 32'(ReqAddr), 32'(BASE));

    // Sticky underrun
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("t5_under", 32'(Underrun), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h02, 1'b0);
    check("t5_sticky", 32'(Underrun), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("t5_clear", 32'(Underrun), 32'd0);

    // Push and pop together at level 1, then mid-frame reset
    cycle(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
    check("t6_level", 32'(Level), 32'd1);
    check("t6_head", 32'(PixelData), 32'h5A);
    cycle(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
    check("t6_rst_data", 32'(PixelData), 32'd0);

    // Randomised traffic across restarts
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 400; i++)
      cycle(1'b0, ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
            8'($urandom), ($urandom_range(0, 2) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vmmu_fetch.md
Name: vmmu_fetch

Overview:
Framebuffer scan-out reader: the requester on one read source of the vmmu time-slot arbiter.
- Drives a sequential read address into one ReqAddrSrc input.
- Captures each byte returned with the matching ReadDataRdy pulse into a small FIFO.
- Presents bytes in order to the pixel pipeline, in the MemClk domain.
- One instance per frame; restarted by FrameStart.

Parameters:
AWIDTH, 19, address width (matches arbiter)
DWIDTH, 8, data width (matches arbiter)
FB_BASE, 0, first framebuffer byte address
FRAME_BYTES, 307200, bytes fetched per frame (640x480, 8bpp); must satisfy FB_BASE+FRAME_BYTES <= 2^AWIDTH
FIFO_DEPTH, 16, FIFO entries, power of two >= 4

Ports:
MemClk  in  1  clock, shared with arbiter
nReset  in  1  synchronous active-low reset
FrameStart  in  1  one-cycle pulse: restart fetch at FB_BASE
ReqAddr  out  AWIDTH  address to arbiter ReqAddrSrcN
ReadData  in  DWIDTH  arbiter ReqReadDataN
ReadDataRdy  in  1  arbiter ReadDataRdyN, one-cycle pulse
PixelPop  in  1  consumer takes head byte this cycle
PixelData  out  DWIDTH  FIFO head (show-ahead)
PixelValid  out  1  FIFO not empty
Level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
Underrun  out  1  sticky: pop attempted while empty
FrameDone  out  1  high once FRAME_BYTES accepted

Behaviour:
- Reset (nReset low at MemClk edge): state IDLE; ReqAddr=FB_BASE; Level=0; PixelValid=0; PixelData=0; Underrun=0; FrameDone=0; byte counter=0.
- States:
  - IDLE: ReadDataRdy ignored; FrameStart -> FETCH.
  - FETCH: capture and advance as below; accepting the FRAME_BYTES-th byte -> DONE.
  - DONE: FrameDone=1; ReadDataRdy ignored; FrameStart -> FETCH.
- Address hold rule:
  - ReqAddr is registered and changes only on an accepted byte or on FrameStart.
  - The arbiter may sample it at any cycle, so every returned byte belongs to the address currently shown.
- Accept, in FETCH: ReadDataRdy=1 and Level<FIFO_DEPTH.
  - Push ReadData.
  - ReqAddr+1 and counter+1, visible next cycle.
- Reject, in FETCH: ReadDataRdy=1 with FIFO full.
  - Byte dropped; ReqAddr unchanged, so the same address is re-read on a later slot.
  - No error flag.
- A full FIFO does not count a same-cycle pop as free space.
- Address wrap: none inside a frame. After the last accept ReqAddr = FB_BASE+FRAME_BYTES and holds in DONE.
- FrameStart, any state, highest priority:
  - ReqAddr=FB_BASE, counter=0, FIFO flushed (Level=0), Underrun=0, FrameDone=0, state FETCH.
  - A simultaneous ReadDataRdy byte is discarded.
  - A simultaneous PixelPop has no effect.
- Pop:
  - PixelPop with PixelValid=1: head removed; next entry on PixelData next cycle.
  - Simultaneous push and pop: Level unchanged, order preserved.
  - Pop with empty FIFO: Underrun<=1 (sticky until FrameStart or reset); Level stays 0; PixelData holds its last value.
- PixelData / PixelValid are registered FIFO-head outputs, valid the cycle after the push (one-cycle write-to-read latency).
- Reset mid-frame: same as the power-up reset values; FIFO contents lost.
- Counter width: clog2(FRAME_BYTES+1); ReqAddr arithmetic is AWIDTH wide.

Decomposition:
- Shared package vga_pkg: FB_BASE, FRAME_BYTES, H/V active sizes, AWIDTH/DWIDTH defaults, fetch state encoding (IDLE/FETCH/DONE).
- One sub-module: sync_fifo (DEPTH, WIDTH parameters; show-ahead; push/pop/full/empty/level; synchronous active-low reset; flush input).
- vmmu_fetch holds the FSM, address/counter and Underrun logic.

Test Plan:
1. Reset, FrameStart, then 3 ReadDataRdy pulses with data 0x11,0x22,0x33 -> ReqAddr steps 0->1->2->3; Level=3; pops return 0x11,0x22,0x33 in order.
2. No pops, 17 pulses with FIFO_DEPTH=16 -> Level=16; 17th byte dropped; ReqAddr=16 and holds; after one pop the next pulse is accepted, ReqAddr=17.
3. FRAME_BYTES=4, pops concurrent with 6 pulses -> FrameDone=1 after the 4th accept; pulses 5 and 6 ignored; ReqAddr=4.
4. FrameStart coincident with ReadDataRdy (data 0xAA) while Level=5 -> Level=0, ReqAddr=FB_BASE, 0xAA not stored, state FETCH.
5. PixelPop on empty FIFO -> Underrun=1, Level=0; stays 1 through later accepts; cleared by next FrameStart.
6. Push and pop in the same cycle at Level=1 -> Level stays 1; head advances to the new byte; nReset low mid-frame -> all outputs at reset values next cycle.
